// File: rtl/dec_7seg_pkg.sv
// Shared constants and the hex-to-glyph mapping for the seven-segment decoder.
// Segment patterns are 7 bits ordered a..g (bit6=a ... bit0=g).
package dec_7seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    // b, c, d are lower-case glyphs
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h0D;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ALL   = 7'h7F;

    // Bit positions within the 8-bit led output.
    localparam int unsigned SEG_IDX_A  = 7;
    localparam int unsigned SEG_IDX_B  = 6;
    localparam int unsigned SEG_IDX_C  = 5;
    localparam int unsigned SEG_IDX_D  = 4;
    localparam int unsigned SEG_IDX_E  = 3;
    localparam int unsigned SEG_IDX_F  = 2;
    localparam int unsigned SEG_IDX_G  = 1;
    localparam int unsigned SEG_IDX_DP = 0;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/dec_7seg_lut.sv
// Combinational nibble-to-glyph lookup (a..g, active-high), no clock.
module dec_7seg_lut
    import dec_7seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = hex_to_seg(i_hex);
    end

endmodule

// File: rtl/dec_7seg.sv
// Registered hex-to-seven-segment decoder with blanking, dp and polarity select.
// Optional lamp-test input enabled by defining DEC_7SEG_LAMP_TEST_EN.
module dec_7seg
    import dec_7seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hex,
    input  logic       dp_in,
    input  logic       blank,
`ifdef DEC_7SEG_LAMP_TEST_EN
    input  logic       lamp_test,
`endif
    output logic [7:0] led
);

    localparam logic [7:0] RST_VAL = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [6:0] w_seg;
    logic [7:0] w_pattern;
    logic [7:0] w_next;
    logic [7:0] r_led;

    dec_7seg_lut u_lut (
        .i_hex (hex),
        .o_seg (w_seg)
    );

    // Priority: lamp test, then blank, then decode; polarity applied last.
    always_comb begin
        w_pattern = {w_seg, dp_in};
        if (blank) begin
            w_pattern = {SEG_BLANK, 1'b0};
        end
`ifdef DEC_7SEG_LAMP_TEST_EN
        if (lamp_test) begin
            w_pattern = {SEG_ALL, 1'b1};
        end
`endif
        w_next = ACTIVE_LOW ? ~w_pattern : w_pattern;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= RST_VAL;
        end else begin
            r_led <= w_next;
        end
    end

    assign led = r_led;

endmodule

// File: tb/tb_dec_7seg.sv
// Directed self-checking bench for dec_7seg; runs an active-high and an
// active-low instance side by side on the same stimulus.
`timescale 1ns/1ps
module tb_dec_7seg;

    logic       clk;
    logic       rst;
    logic [3:0] hex;
    logic       dp_in;
    logic       blank;
`ifdef DEC_7SEG_LAMP_TEST_EN
    logic       lamp_test;
`endif
    logic [7:0] led_hi;
    logic [7:0] led_lo;

    int checks;
    int errors;

    localparam logic [7:0] EXP_TAB [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E
    };

    dec_7seg #(.ACTIVE_LOW(1'b0)) u_hi (
        .clk       (clk),
        .rst       (rst),
        .hex       (hex),
        .dp_in     (dp_in),
        .blank     (blank),
`ifdef DEC_7SEG_LAMP_TEST_EN
        .lamp_test (lamp_test),
`endif
        .led       (led_hi)
    );

    dec_7seg #(.ACTIVE_LOW(1'b1)) u_lo (
        .clk       (clk),
        .rst       (rst),
        .hex       (hex),
        .dp_in     (dp_in),
        .blank     (blank),
`ifdef DEC_7SEG_LAMP_TEST_EN
        .lamp_test (lamp_test),
`endif
        .led       (led_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        checks++;
        if (led_hi !== 8'h00) begin
            errors++;
            $display("FAIL reset_hi got %h want %h", led_hi, 8'h00);
        end
        checks++;
        if (led_lo !== 8'hFF) begin
            errors++;
            $display("FAIL reset_lo got %h want %h", led_lo, 8'hFF);
        end
        @(negedge clk);
        hex = 4'h8; dp_in = 1'b0; blank = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (led_hi !== 8'hFE) begin
            errors++;
            $display("FAIL reset_release got %h want %h", led_hi, 8'hFE);
        end
        // Mid-cycle async assertion must clear led without an edge.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (led_hi !== 8'h00) begin
            errors++;
            $display("FAIL reset_async_hi got %h want %h", led_hi, 8'h00);
        end
        checks++;
        if (led_lo !== 8'hFF) begin
            errors++;
            $display("FAIL reset_async_lo got %h want %h", led_lo, 8'hFF);
        end
        @(posedge clk); #1;
        checks++;
        if (led_hi !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold_edge got %h want %h", led_hi, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (led_hi !== 8'hFE) begin
            errors++;
            $display("FAIL reset_rerelease got %h want %h", led_hi, 8'hFE);
        end
    endtask

    task automatic test_sweep;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            hex = 4'(i % 16); dp_in = 1'b0; blank = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (led_hi !== EXP_TAB[i % 16]) begin
                errors++;
                $display("FAIL sweep_hi[%0d] got %h want %h", i, led_hi, EXP_TAB[i % 16]);
            end
            checks++;
            if (led_lo !== ~EXP_TAB[i % 16]) begin
                errors++;
                $display("FAIL sweep_lo[%0d] got %h want %h", i, led_lo, ~EXP_TAB[i % 16]);
            end
        end
    endtask

    task automatic test_latency;
        @(negedge clk);
        hex = 4'h1;
        @(posedge clk); #1;
        @(negedge clk);
        hex = 4'h7;
        #1;
        checks++;
        if (led_hi !== 8'h60) begin
            errors++;
            $display("FAIL latency_hold got %h want %h", led_hi, 8'h60);
        end
        @(posedge clk); #1;
        checks++;
        if (led_hi !== 8'hE0) begin
            errors++;
            $display("FAIL latency_update got %h want %h", led_hi, 8'hE0);
        end
    endtask

    task automatic test_dp;
        @(negedge clk);
        hex = 4'h3; dp_in = 1'b1; blank = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (led_hi !== 8'hF3) begin
            errors++;
            $display("FAIL dp_on got %h want %h", led_hi, 8'hF3);
        end
        @(negedge clk);
        dp_in = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (led_hi !== 8'hF2) begin
            errors++;
            $display("FAIL dp_off got %h want %h", led_hi, 8'hF2);
        end
    endtask

    task automatic test_blank;
        @(negedge clk);
        hex = 4'hA; dp_in = 1'b1; blank = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (led_hi !== 8'h00) begin
            errors++;
            $display("FAIL blank_hi got %h want %h", led_hi, 8'h00);
        end
        checks++;
        if (led_lo !== 8'hFF) begin
            errors++;
            $display("FAIL blank_lo got %h want %h", led_lo, 8'hFF);
        end
        @(negedge clk);
        blank = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (led_hi !== 8'hEF) begin
            errors++;
            $display("FAIL unblank_hi got %h want %h", led_hi, 8'hEF);
        end
        checks++;
        if (led_lo !== 8'h10) begin
            errors++;
            $display("FAIL unblank_lo got %h want %h", led_lo, 8'h10);
        end
    endtask

    task automatic test_polarity;
        @(negedge clk);
        hex = 4'h0; dp_in = 1'b0; blank = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (led_lo !== 8'h03) begin
            errors++;
            $display("FAIL polarity_lo got %h want %h", led_lo, 8'h03);
        end
        @(negedge clk);
        hex = 4'hD; dp_in = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (led_lo !== 8'h84) begin
            errors++;
            $display("FAIL polarity_lo_dp got %h want %h", led_lo, 8'h84);
        end
    endtask

`ifdef DEC_7SEG_LAMP_TEST_EN
    task automatic test_lamp;
        @(negedge clk);
        hex = 4'h5; dp_in = 1'b0; blank = 1'b1; lamp_test = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (led_hi !== 8'hFF) begin
            errors++;
            $display("FAIL lamp_hi got %h want %h", led_hi, 8'hFF);
        end
        checks++;
        if (led_lo !== 8'h00) begin
            errors++;
            $display("FAIL lamp_lo got %h want %h", led_lo, 8'h00);
        end
        @(negedge clk);
        lamp_test = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (led_hi !== 8'h00) begin
            errors++;
            $display("FAIL lamp_release_hi got %h want %h", led_hi, 8'h00);
        end
        checks++;
        if (led_lo !== 8'hFF) begin
            errors++;
            $display("FAIL lamp_release_lo got %h want %h", led_lo, 8'hFF);
        end
        @(negedge clk);
        blank = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        hex    = 4'h0;
        dp_in  = 1'b0;
        blank  = 1'b0;
`ifdef DEC_7SEG_LAMP_TEST_EN
        lamp_test = 1'b0;
`endif
        #12;
        test_reset;
        test_sweep;
        test_latency;
        test_dp;
        test_blank;
        test_polarity;
`ifdef DEC_7SEG_LAMP_TEST_EN
        test_lamp;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
